// File: rtl/queue_arbiter.sv
// Round-robin arbiter granting queue heads to a shared multi-cycle unit.
// Latency of the granted entry sets how long the unit stays occupied.
module queue_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int LAT_W   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ*LAT_W-1:0] req_lat,
  output logic [NUM_REQ-1:0]       deque,
  output logic                     issue_valid,
  output logic [WIDTH-1:0]         issue_data,
  output logic [1:0]               issue_src,
  output logic                     busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;
  logic [IW-1:0]    sel;
  logic [IW-1:0]    sel_next;
  logic [LAT_W-1:0] lat_sel;
  logic             found;
  logic             grant;

  // First requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  assign lat_sel  = req_lat[sel*LAT_W +: LAT_W];
  assign sel_next = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

  // reset gates the strobe so the queues see nothing while held.
  assign grant = reset && (state_q == IDLE) && !stall && !flush && found;
  assign deque = grant ? (NUM_REQ'(1) << sel) : '0;
  assign busy  = (state_q == BUSY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          ptr_d = sel_next;
          if (lat_sel > LAT_W'(1)) begin
            state_d = BUSY;
            cnt_d   = lat_sel - LAT_W'(1);
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!stall) begin
          if (cnt_q <= LAT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - LAT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      issue_valid <= 1'b0;
      issue_data  <= '0;
      issue_src   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      issue_valid <= grant;
      if (grant) begin
        issue_data <= req_data[sel*WIDTH +: WIDTH];
        issue_src  <= 2'(sel);
      end
    end
  end

endmodule

// File: tb/tb_queue_arbiter.sv
// Directed bench for queue_arbiter with a scoreboard of expected issues.
// Grants are predicted per step and matched against the registered issue.
module tb_queue_arbiter;

  logic         clk;
  logic         reset;
  logic         stall;
  logic         flush;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [15:0]  req_lat;
  logic [3:0]   deque;
  logic         issue_valid;
  logic [31:0]  issue_data;
  logic [1:0]   issue_src;
  logic         busy;

  int checks;
  int errors;
  int seq;

  logic [1:0]  sb_src[$];
  logic [31:0] sb_data[$];
  logic [1:0]  last_src;
  logic [31:0] last_data;

  queue_arbiter #(
    .NUM_REQ(4),
    .WIDTH(32),
    .LAT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .req(req),
    .req_data(req_data),
    .req_lat(req_lat),
    .deque(deque),
    .issue_valid(issue_valid),
    .issue_data(issue_data),
    .issue_src(issue_src),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < 4; i++)
      req_data[i*32 +: 32] = {8'hD0 + 8'(i), 24'(seq)};
  endtask

  // One clock: drive at negedge, check strobe, then check issue after edge.
  task automatic step(input logic [3:0] r, input logic [15:0] lat,
                      input logic s, input logic f, input int g,
                      input logic b);
    logic [3:0]  exp_dq;
    logic [1:0]  got_src;
    logic [31:0] got_data;
    @(negedge clk);
    seq++;
    req     = r;
    req_lat = lat;
    stall   = s;
    flush   = f;
    set_data();
    #1;
    exp_dq = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("deque", 32'(deque), 32'(exp_dq));
    chk("busy", 32'(busy), 32'(b));
    if (g >= 0) begin
      sb_src.push_back(2'(g));
      sb_data.push_back(req_data[g*32 +: 32]);
    end
    @(posedge clk);
    #1;
    chk("issue_valid", 32'(issue_valid), (g >= 0) ? 32'd1 : 32'd0);
    if (issue_valid) begin
      chk("sb_depth", 32'(sb_src.size()), 32'd1);
      if (sb_src.size() > 0) begin
        got_src  = sb_src.pop_front();
        got_data = sb_data.pop_front();
        chk("issue_src", 32'(issue_src), 32'(got_src));
        chk("issue_data", issue_data, got_data);
        last_src  = got_src;
        last_data = got_data;
      end
    end else begin
      chk("hold_src", 32'(issue_src), 32'(last_src));
      chk("hold_data", issue_data, last_data);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_deque"}, 32'(deque), 32'd0);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_src"}, 32'(issue_src), 32'd0);
    chk({tag, "_data"}, issue_data, 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    seq       = 0;
    last_src  = '0;
    last_data = '0;
    reset     = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    req       = 4'b1111;
    req_lat   = 16'h1111;
    set_data();
    #1;
    chk_zero("rst");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    @(negedge clk);
    req   = 4'b0000;
    reset = 1'b1;

    // rotation, queue 3 uses lat 0 which acts as 1
    step(4'b1111, 16'h0111, 0, 0, 0, 0);
    step(4'b1111, 16'h0111, 0, 0, 1, 0);
    step(4'b1111, 16'h0111, 0, 0, 2, 0);
    step(4'b1111, 16'h0111, 0, 0, 3, 0);
    step(4'b1111, 16'h0111, 0, 0, 0, 0);

    // move ptr to 3, then skip and wrap
    step(4'b0100, 16'h1111, 0, 0, 2, 0);
    step(4'b0101, 16'h1111, 0, 0, 0, 0);
    step(4'b0101, 16'h1111, 0, 0, 2, 0);
    step(4'b0101, 16'h1111, 0, 0, 0, 0);

    // ptr to 0, then lat0=3 occupancy
    step(4'b1000, 16'h1111, 0, 0, 3, 0);
    step(4'b0011, 16'h0013, 0, 0, 0, 0);
    step(4'b0011, 16'h0013, 0, 0, -1, 1);
    step(4'b0011, 16'h0013, 0, 0, -1, 1);
    step(4'b0011, 16'h0013, 0, 0, 1, 0);

    // lat=4 grant with 2-cycle stall while busy
    step(4'b0100, 16'h0400, 0, 0, 2, 0);
    step(4'b0100, 16'h0400, 1, 0, -1, 1);
    step(4'b0100, 16'h0400, 1, 0, -1, 1);
    step(4'b0100, 16'h0400, 0, 0, -1, 1);
    step(4'b0100, 16'h0400, 0, 0, -1, 1);
    step(4'b0100, 16'h0400, 0, 0, -1, 1);
    step(4'b0100, 16'h0100, 0, 0, 2, 0);

    // stall in idle, flush+stall, dropped request
    step(4'b1111, 16'h1111, 1, 0, -1, 0);
    step(4'b1111, 16'h1111, 0, 0, 3, 0);
    step(4'b1111, 16'h1111, 1, 1, -1, 0);
    step(4'b0000, 16'h1111, 0, 0, -1, 0);

    // flush while busy with cnt=2
    step(4'b0010, 16'h0030, 0, 0, 1, 0);
    step(4'b1111, 16'h1111, 0, 1, -1, 1);
    step(4'b1111, 16'h1111, 0, 0, 2, 0);

    // reset mid-busy with ptr at 3
    step(4'b0100, 16'h0300, 0, 0, 2, 0);
    step(4'b1111, 16'h1111, 0, 0, -1, 1);
    @(negedge clk);
    req   = 4'b1111;
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    last_src  = '0;
    last_data = '0;
    @(negedge clk);
    req   = 4'b0000;
    reset = 1'b1;
    step(4'b1111, 16'h1111, 0, 0, 0, 0);
    step(4'b1111, 16'h1111, 0, 0, 1, 0);

    chk("sb_left", 32'(sb_src.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesting queues.
REQ-002 SHALL have parameter WIDTH, default 32: entry width per queue.
REQ-003 SHALL have parameter LAT_W, default 4: width of the per-request latency field.
REQ-004 SHALL have one clock, `clk` (input, 1), with all state on the rising edge.
REQ-005 SHALL have `reset` (input, 1), asynchronous and active-low.
REQ-006 SHALL have `stall` (input, 1): global pipeline stall.
REQ-007 SHALL have `flush` (input, 1): synchronous flush.
REQ-008 SHALL have `req` (input, NUM_REQ): bit i high means queue i is non-empty.
REQ-009 SHALL have `req_data` (input, NUM_REQ*WIDTH): head entry of queue i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have `req_lat` (input, NUM_REQ*LAT_W): occupancy cycles of the shared unit for queue i's head.
REQ-011 SHALL have `deque` (output, NUM_REQ): one-hot, combinational dequeue strobe to the queues.
REQ-012 SHALL have `issue_valid` (output, 1): registered one-cycle issue pulse.
REQ-013 SHALL have `issue_data` (output, WIDTH): registered issued entry.
REQ-014 SHALL have `issue_src` (output, 2): registered index of the granted queue (sized for NUM_REQ=4).
REQ-015 SHALL have `busy` (output, 1): high while the unit is occupied (state BUSY).

Function
REQ-016 SHALL implement an FSM with exactly two states, IDLE and BUSY.
REQ-017 SHALL keep a round-robin pointer `ptr` (0..NUM_REQ-1) and a LAT_W-bit counter `cnt`.
REQ-018 SHALL define the grant condition as state==IDLE & ~stall & ~flush & |req.
REQ-019 On grant, SHALL select g = the first set bit of req, scanning from ptr upward and wrapping past NUM_REQ-1 to 0.
REQ-020 SHALL drive deque[g]=1 combinationally in the grant cycle; all other cycles SHALL drive deque=0.
REQ-021 On the edge ending a grant cycle, SHALL set issue_valid=1, issue_data=req_data slice g, issue_src=g, ptr=(g+1) mod NUM_REQ.
REQ-022 SHALL clear issue_valid on every cycle that is not immediately after a grant.
REQ-023 SHALL hold issue_data and issue_src until the next grant.
REQ-024 SHALL use L = lat of queue g, with L=0 treated as 1.
REQ-025 If L==1, SHALL remain in IDLE, so back-to-back grants on consecutive cycles are allowed.
REQ-026 If L>1, SHALL move to BUSY with cnt=L-1.
REQ-027 In BUSY, SHALL make no grant; on each cycle with ~stall, cnt SHALL decrement.
REQ-028 When cnt==1 and ~stall in BUSY, SHALL set cnt=0 and move to IDLE.
REQ-029 As a result, consecutive grants SHALL be separated by exactly L unstalled cycles.
REQ-030 Under stall (without flush), SHALL freeze state, cnt and ptr, with deque=0 and issue_valid=0 next cycle.
REQ-031 Under flush, SHALL set state=IDLE, cnt=0, deque=0 and issue_valid=0 next cycle, leaving ptr unchanged.
REQ-032 If flush and stall are both high, flush SHALL win.
REQ-033 SHALL not change busy combinationally; it reflects registered state only.
REQ-034 SHALL handle a request dropping between cycles with no side effect.
REQ-035 SHALL ignore req bits while in BUSY.

Reset
REQ-036 While reset is low, SHALL force state=IDLE, ptr=0, cnt=0, issue_valid=0, issue_data=0, issue_src=0, busy=0.
REQ-037 While reset is low, SHALL force deque=0 regardless of req.
REQ-038 Reset asserted mid-BUSY SHALL abort immediately.
REQ-039 After reset deasserts, the first grant SHALL be made no earlier than the first rising edge.

Verification
REQ-040 Rotation: req=4'b1111, all lat=1, no stall -> grants to queues 0,1,2,3,0 on consecutive cycles; issue_src follows 0,1,2,3,0; exactly one deque bit set per cycle.
REQ-041 Skip and wrap: ptr=3, req=4'b0101 -> grant to queue 0, then 2, then 0 (src 0, 2, 0).
REQ-042 Multi-cycle occupancy: req=4'b0011, lat0=3, lat1=1 -> grant 0 at cycle t; busy high for t+1..t+2; grant 1 at t+3.
REQ-043 Stall in BUSY: lat=4 grant at t, stall high for 2 cycles at t+1 -> next grant at t+6; cnt held during stall.
REQ-044 Flush: flush during BUSY with cnt=2 -> next cycle busy=0 and issue_valid=0; grant resumes the following cycle from the unchanged ptr.
REQ-045 Reset mid-operation: reset low while BUSY with req=4'b1111 -> deque=0 and all outputs zero within the same cycle; after release, first grant goes to queue 0.
